// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multicycle_ctrl
//  Description : Control FSM for a multicycle MIPS datapath. The FSM sequences
//                fetch, decode and the per-class execute/writeback states. It
//                flags unsupported opcodes and counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero,
    output logic                pcWrite,
    output logic                pcWriteCond,
    output logic                irWrite,
    output logic                memRead,
    output logic                memWrite,
    output logic                regWrite,
    output logic                extendSignal,
    output logic                aluSrcA,
    output logic [1:0]          aluSrcB,
    output logic [1:0]          aluOp,
    output logic [1:0]          pcSource,
    output logic                regDst,
    output logic                memToReg,
    output logic                iorD,
    output logic [3:0]          state,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    // Opcodes recognised by the decoder
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXE   = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [5:0]          r_opcode;
    logic [RETIRE_W-1:0] r_retired;

    // funct is consumed by the external ALU decoder and zero is gated in the
    // datapath, so neither affects sequencing here.
    logic                w_unused_inputs;
    assign w_unused_inputs = ^{funct, zero};

    // Raw (pre-reset-gating) datapath controls
    logic       w_pcWrite, w_pcWriteCond, w_irWrite, w_memRead, w_memWrite, w_regWrite;
    logic       w_illegal;
    logic       w_retire;
    logic [5:0] w_ext_op;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Opcode is captured during DECODE for use by later states
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opcode <= 6'b000000;
        end else if (r_state == S_DECODE) begin
            r_opcode <= opcode;
        end
    end

    // Retired count advances on every completing return to FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + RETIRE_W'(1);
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        w_next        = S_FETCH;
        w_pcWrite     = 1'b0;
        w_pcWriteCond = 1'b0;
        w_irWrite     = 1'b0;
        w_memRead     = 1'b0;
        w_memWrite    = 1'b0;
        w_regWrite    = 1'b0;
        aluSrcA       = 1'b0;
        aluSrcB       = 2'b00;
        aluOp         = 2'b00;
        pcSource      = 2'b00;
        regDst        = 1'b0;
        memToReg      = 1'b0;
        iorD          = 1'b0;
        w_illegal     = 1'b0;
        w_retire      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_memRead = 1'b1;
                w_irWrite = 1'b1;
                w_pcWrite = 1'b1;
                aluSrcB   = 2'b01;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while decoding
                aluSrcB = 2'b11;
                case (opcode)
                    c_OP_RTYPE:                     w_next = S_RTEXE;
                    c_OP_LW, c_OP_SW:               w_next = S_MEMADR;
                    c_OP_BEQ:                       w_next = S_BRANCH;
                    c_OP_ADDI, c_OP_ANDI, c_OP_ORI: w_next = S_IEXE;
                    c_OP_J:                         w_next = S_JUMP;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                w_next  = (r_opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_memRead = 1'b1;
                iorD      = 1'b1;
                w_next    = S_MEMWB;
            end
            S_MEMWB: begin
                w_regWrite = 1'b1;
                memToReg   = 1'b1;
                w_retire   = 1'b1;
            end
            S_MEMWR: begin
                w_memWrite = 1'b1;
                iorD       = 1'b1;
                w_retire   = 1'b1;
            end
            S_RTEXE: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
                w_next  = S_RTWB;
            end
            S_RTWB: begin
                w_regWrite = 1'b1;
                regDst     = 1'b1;
                w_retire   = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA       = 1'b1;
                aluOp         = 2'b01;
                w_pcWriteCond = 1'b1;
                pcSource      = 2'b01;
                w_retire      = 1'b1;
            end
            S_IEXE: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                aluOp   = 2'b11;
                w_next  = S_IWB;
            end
            S_IWB: begin
                w_regWrite = 1'b1;
                w_retire   = 1'b1;
            end
            S_JUMP: begin
                w_pcWrite = 1'b1;
                pcSource  = 2'b10;
                w_retire  = 1'b1;
            end
            default: begin
                // Unused encodings 12-15 recover to FETCH
                w_next = S_FETCH;
            end
        endcase
    end

    // During DECODE the latched copy is not yet valid, so use the live opcode
    assign w_ext_op     = (r_state == S_DECODE) ? opcode : r_opcode;
    assign extendSignal = !((w_ext_op == c_OP_ANDI) || (w_ext_op == c_OP_ORI));

    // Write strobes are held off for as long as reset is asserted
    assign pcWrite     = w_pcWrite     & ~reset;
    assign pcWriteCond = w_pcWriteCond & ~reset;
    assign irWrite     = w_irWrite     & ~reset;
    assign memRead     = w_memRead     & ~reset;
    assign memWrite    = w_memWrite    & ~reset;
    assign regWrite    = w_regWrite    & ~reset;
    assign illegal     = w_illegal     & ~reset;

    assign state   = r_state;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_multicycle_ctrl
//  Description : Directed self-checking bench for mips_multicycle_ctrl
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

    localparam int RETIRE_W = 4;

    // Expected output vectors, field order:
    // pcWrite pcWriteCond irWrite memRead memWrite regWrite | aluSrcA aluSrcB aluOp pcSource | regDst memToReg iorD
    localparam logic [15:0] O_FETCH  = 16'b1_0_1_1_0_0_0_01_00_00_0_0_0;
    localparam logic [15:0] O_DECODE = 16'b0_0_0_0_0_0_0_11_00_00_0_0_0;
    localparam logic [15:0] O_MEMADR = 16'b0_0_0_0_0_0_1_10_00_00_0_0_0;
    localparam logic [15:0] O_MEMRD  = 16'b0_0_0_1_0_0_0_00_00_00_0_0_1;
    localparam logic [15:0] O_MEMWB  = 16'b0_0_0_0_0_1_0_00_00_00_0_1_0;
    localparam logic [15:0] O_MEMWR  = 16'b0_0_0_0_1_0_0_00_00_00_0_0_1;
    localparam logic [15:0] O_RTEXE  = 16'b0_0_0_0_0_0_1_00_10_00_0_0_0;
    localparam logic [15:0] O_RTWB   = 16'b0_0_0_0_0_1_0_00_00_00_1_0_0;
    localparam logic [15:0] O_BRANCH = 16'b0_1_0_0_0_0_1_00_01_01_0_0_0;
    localparam logic [15:0] O_IEXE   = 16'b0_0_0_0_0_0_1_10_11_00_0_0_0;
    localparam logic [15:0] O_IWB    = 16'b0_0_0_0_0_1_0_00_00_00_0_0_0;
    localparam logic [15:0] O_JUMP   = 16'b1_0_0_0_0_0_0_00_00_10_0_0_0;

    logic                clk;
    logic                reset;
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                zero;
    logic                pcWrite, pcWriteCond, irWrite, memRead, memWrite, regWrite;
    logic                extendSignal, aluSrcA, regDst, memToReg, iorD, illegal;
    logic [1:0]          aluSrcB, aluOp, pcSource;
    logic [3:0]          state;
    logic [RETIRE_W-1:0] retired;
    logic [15:0]         outs;

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;

    assign outs = {pcWrite, pcWriteCond, irWrite, memRead, memWrite, regWrite,
                   aluSrcA, aluSrcB, aluOp, pcSource, regDst, memToReg, iorD};

    mips_multicycle_ctrl #(.RETIRE_W(RETIRE_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .funct        (funct),
        .zero         (zero),
        .pcWrite      (pcWrite),
        .pcWriteCond  (pcWriteCond),
        .irWrite      (irWrite),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .regWrite     (regWrite),
        .extendSignal (extendSignal),
        .aluSrcA      (aluSrcA),
        .aluSrcB      (aluSrcB),
        .aluOp        (aluOp),
        .pcSource     (pcSource),
        .regDst       (regDst),
        .memToReg     (memToReg),
        .iorD         (iorD),
        .state        (state),
        .illegal      (illegal),
        .retired      (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        opcode = 6'b000000;
        funct  = 6'b000000;
        zero   = 1'b0;
        step();
        checks++;
        if (state !== 4'd0 || retired !== 4'd0 || outs[15:10] !== 6'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: state=%0d retired=%0d strobes=%b illegal=%b, expected 0 0 000000 0",
                     state, retired, outs[15:10], illegal);
        end
        checks++;
        if (extendSignal !== 1'b1) begin
            errors++;
            $display("FAIL reset_extend: extendSignal=%b, expected 1", extendSignal);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || outs !== O_FETCH) begin
            errors++;
            $display("FAIL reset_release: state=%0d outs=%h, expected 0 %h", state, outs, O_FETCH);
        end
    endtask

    task automatic test_lw();
        logic [3:0]  st[5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic [15:0] ov[5] = '{O_FETCH, O_DECODE, O_MEMADR, O_MEMRD, O_MEMWB};
        opcode = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== st[i] || outs !== ov[i] || illegal !== 1'b0) begin
                errors++;
                $display("FAIL lw_cycle%0d: state=%0d outs=%h illegal=%b, expected %0d %h 0",
                         i, state, outs, illegal, st[i], ov[i]);
            end
            if (i > 0) begin
                checks++;
                if (extendSignal !== 1'b1) begin
                    errors++;
                    $display("FAIL lw_extend%0d: extendSignal=%b, expected 1", i, extendSignal);
                end
            end
            step();
        end
        exp_ret = (exp_ret + 1) % 16;
        checks++;
        if (state !== 4'd0 || retired !== 4'(exp_ret)) begin
            errors++;
            $display("FAIL lw_retire: state=%0d retired=%0d, expected 0 %0d", state, retired, exp_ret);
        end
    endtask

    task automatic test_ori();
        logic [3:0]  st[4] = '{4'd0, 4'd1, 4'd9, 4'd10};
        logic [15:0] ov[4] = '{O_FETCH, O_DECODE, O_IEXE, O_IWB};
        opcode = 6'b001101;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== st[i] || outs !== ov[i]) begin
                errors++;
                $display("FAIL ori_cycle%0d: state=%0d outs=%h, expected %0d %h", i, state, outs, st[i], ov[i]);
            end
            if (i > 0) begin
                checks++;
                if (extendSignal !== 1'b0) begin
                    errors++;
                    $display("FAIL ori_extend%0d: extendSignal=%b, expected 0", i, extendSignal);
                end
            end
            step();
        end
        exp_ret = (exp_ret + 1) % 16;
        checks++;
        if (state !== 4'd0 || retired !== 4'(exp_ret)) begin
            errors++;
            $display("FAIL ori_retire: state=%0d retired=%0d, expected 0 %0d", state, retired, exp_ret);
        end
    endtask

    task automatic test_branch();
        logic [3:0]  st[3] = '{4'd0, 4'd1, 4'd8};
        logic [15:0] ov[3] = '{O_FETCH, O_DECODE, O_BRANCH};
        opcode = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (state !== st[i] || outs !== ov[i]) begin
                    errors++;
                    $display("FAIL beq_z%0d_cycle%0d: state=%0d outs=%h, expected %0d %h",
                             z, i, state, outs, st[i], ov[i]);
                end
                step();
            end
        end
        zero = 1'b0;
        exp_ret = (exp_ret + 2) % 16;
        checks++;
        if (state !== 4'd0 || retired !== 4'(exp_ret)) begin
            errors++;
            $display("FAIL beq_retire: state=%0d retired=%0d, expected 0 %0d", state, retired, exp_ret);
        end
    endtask

    task automatic test_rtype_sw_j();
        logic [5:0]  ops[3]   = '{6'b000000, 6'b101011, 6'b000010};
        int          len[3]   = '{4, 4, 3};
        logic [3:0]  st[3][4] = '{'{4'd0, 4'd1, 4'd6, 4'd7},
                                  '{4'd0, 4'd1, 4'd2, 4'd5},
                                  '{4'd0, 4'd1, 4'd11, 4'd0}};
        logic [15:0] ov[3][4] = '{'{O_FETCH, O_DECODE, O_RTEXE, O_RTWB},
                                  '{O_FETCH, O_DECODE, O_MEMADR, O_MEMWR},
                                  '{O_FETCH, O_DECODE, O_JUMP, O_FETCH}};
        for (int k = 0; k < 3; k++) begin
            opcode = ops[k];
            funct  = 6'(6'd17 * (k + 1));
            for (int i = 0; i < len[k]; i++) begin
                checks++;
                if (state !== st[k][i] || outs !== ov[k][i]) begin
                    errors++;
                    $display("FAIL op%b_cycle%0d: state=%0d outs=%h, expected %0d %h",
                             ops[k], i, state, outs, st[k][i], ov[k][i]);
                end
                step();
            end
            exp_ret = (exp_ret + 1) % 16;
            checks++;
            if (state !== 4'd0 || retired !== 4'(exp_ret)) begin
                errors++;
                $display("FAIL op%b_retire: state=%0d retired=%0d, expected 0 %0d",
                         ops[k], state, retired, exp_ret);
            end
        end
    endtask

    task automatic test_illegal();
        int pulses = 0;
        opcode = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            if (illegal === 1'b1) pulses++;
            checks++;
            if (state !== ((i == 1) ? 4'd1 : 4'd0) || illegal !== (i == 1)) begin
                errors++;
                $display("FAIL illegal_cycle%0d: state=%0d illegal=%b, expected %0d %b",
                         i, state, illegal, (i == 1) ? 1 : 0, (i == 1));
            end
            if (i < 2) step();
        end
        checks++;
        if (pulses != 1 || retired !== 4'(exp_ret)) begin
            errors++;
            $display("FAIL illegal_pulse: pulses=%0d retired=%0d, expected 1 %0d", pulses, retired, exp_ret);
        end
    endtask

    task automatic test_wrap();
        opcode = 6'b000010;
        while (exp_ret != 15) begin
            step(); step(); step();
            exp_ret = (exp_ret + 1) % 16;
        end
        checks++;
        if (retired !== 4'hF) begin
            errors++;
            $display("FAIL wrap_full: retired=%0d, expected 15", retired);
        end
        step(); step(); step();
        exp_ret = 0;
        checks++;
        if (retired !== 4'd0 || state !== 4'd0) begin
            errors++;
            $display("FAIL wrap_zero: retired=%0d state=%0d, expected 0 0", retired, state);
        end
    endtask

    task automatic test_reset_mid();
        opcode = 6'b100011;
        step(); step(); step();
        checks++;
        if (state !== 4'd3) begin
            errors++;
            $display("FAIL midrst_setup: state=%0d, expected 3", state);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || retired !== 4'd0 || outs[15:10] !== 6'b0) begin
            errors++;
            $display("FAIL midrst_abort: state=%0d retired=%0d strobes=%b, expected 0 0 000000",
                     state, retired, outs[15:10]);
        end
        step();
        reset = 1'b0;
        #1;
        exp_ret = 0;
        checks++;
        if (state !== 4'd0 || outs !== O_FETCH) begin
            errors++;
            $display("FAIL midrst_resume: state=%0d outs=%h, expected 0 %h", state, outs, O_FETCH);
        end
        step(); step(); step(); step(); step();
        exp_ret = 1;
        checks++;
        if (state !== 4'd0 || retired !== 4'd1) begin
            errors++;
            $display("FAIL midrst_complete: state=%0d retired=%0d, expected 0 1", state, retired);
        end
    endtask

    task automatic test_back_to_back();
        opcode = 6'b001100;
        step(); step(); step(); step();
        opcode = 6'b100011;
        // Latched andi still drives the extender during the next FETCH
        checks++;
        if (state !== 4'd0 || extendSignal !== 1'b0) begin
            errors++;
            $display("FAIL b2b_fetch_extend: state=%0d extendSignal=%b, expected 0 0", state, extendSignal);
        end
        step();
        checks++;
        if (state !== 4'd1 || extendSignal !== 1'b1) begin
            errors++;
            $display("FAIL b2b_decode_extend: state=%0d extendSignal=%b, expected 1 1", state, extendSignal);
        end
        step(); step(); step(); step();
        exp_ret = (exp_ret + 2) % 16;
        checks++;
        if (state !== 4'd0 || retired !== 4'(exp_ret)) begin
            errors++;
            $display("FAIL b2b_retire: state=%0d retired=%0d, expected 0 %0d", state, retired, exp_ret);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_ori();
        test_branch();
        test_rtype_sw_j();
        test_illegal();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
